sdram_arbiter: RTL

Top-level sequencer for the single-port SDRAM. It holds the bus during power-up init, runs the auto-refresh interval timer and drives ref_req, and grants the bus to the refresh, write and read engines under fixed priority. It multiplexes the granted engine's command, address and bank onto the SDRAM pins. It sits between sdram_init/sdram_aref/sdram_write/sdram_read and the pad ring.

---
 rtl/sdram_pkg.sv | 27 ++
 rtl/sdram_ref_timer.sv | 52 +++++
 rtl/sdram_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared constants and types for the SDRAM controller slice.
//   - SDRAM command encodings {cs_n, ras_n, cas_n, we_n}
//   - one-hot arbiter state type
//   - default refresh interval / engine timeout
package sdram_pkg;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;

    // 15 us at 50 MHz
    localparam int REF_PERIOD_DEF = 750;
    localparam int TIMEOUT_DEF    = 1023;
    localparam int TMO_W          = 10;

    typedef enum logic [4:0] {
        S_INIT  = 5'b00001,
        S_ARBIT = 5'b00010,
        S_REF   = 5'b00100,
        S_WR    = 5'b01000,
        S_RD    = 5'b10000
    } arb_state_e;

endpackage

// File: rtl/sdram_ref_timer.sv
// sdram_ref_timer: auto-refresh interval timer.
//   clk_i, rst_ni  : clock, async active-low reset
//   init_done_i    : timer only runs once power-up init is complete
//   grant_i        : refresh grant being registered on this edge (clears ref_req)
//   ref_req_o      : refresh pending
//   ref_miss_o     : sticky, an interval expired while a refresh was still pending
module sdram_ref_timer
    import sdram_pkg::*;
#(
    parameter int REF_PERIOD = REF_PERIOD_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic init_done_i,
    input  logic grant_i,
    output logic ref_req_o,
    output logic ref_miss_o
);

    localparam int CW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          miss_q, miss_d;
    logic          wrap;

    always_comb begin
        wrap  = init_done_i && (cnt_q == CW'(REF_PERIOD - 1));
        cnt_d = cnt_q;
        if (init_done_i)
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
        // a wrap on the grant edge wins: the new interval's request survives
        req_d  = wrap | (req_q & ~grant_i);
        miss_d = miss_q | (wrap & req_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            req_q  <= 1'b0;
            miss_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            req_q  <= req_d;
            miss_q <= miss_d;
        end
    end

    assign ref_req_o  = req_q;
    assign ref_miss_o = miss_q;

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: top-level SDRAM bus sequencer.
//   Holds the bus for sdram_init, then grants it to refresh > write > read.
//   Inputs : sclk, s_rst_n, init_done, per-engine cmd/addr(/bank), wr_req,
//            rd_req and per-engine end flags.
//   Outputs: ref_en/wr_en/rd_en (1-cycle grants), ref_req, ref_miss,
//            arb_err (sticky timeout), sdram_cke/cmd/addr/bank pin mux.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int REF_PERIOD = REF_PERIOD_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic        sclk,
    input  logic        s_rst_n,
    input  logic        init_done,
    input  logic [3:0]  init_cmd,
    input  logic [11:0] init_addr,
    input  logic [3:0]  ref_cmd,
    input  logic [11:0] ref_addr,
    input  logic        flag_ref_end,
    input  logic        wr_req,
    input  logic [3:0]  wr_cmd,
    input  logic [11:0] wr_addr,
    input  logic [1:0]  wr_bank,
    input  logic        flag_wr_end,
    input  logic        rd_req,
    input  logic [3:0]  rd_cmd,
    input  logic [11:0] rd_addr,
    input  logic [1:0]  rd_bank,
    input  logic        flag_rd_end,
    output logic        ref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic        ref_req,
    output logic        ref_miss,
    output logic        arb_err,
    output logic        sdram_cke,
    output logic [3:0]  sdram_cmd,
    output logic [11:0] sdram_addr,
    output logic [1:0]  sdram_bank
);

    arb_state_e       state_q;
    logic [TMO_W-1:0] tmo_q;
    logic             ref_en_q, wr_en_q, rd_en_q;
    logic             arb_err_q;
    logic             cke_q;
    logic             ref_grant;
    logic             tmo_hit;

    // refresh wins arbitration whenever it is pending in S_ARBIT
    assign ref_grant = (state_q == S_ARBIT) && ref_req;
    assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT - 1));

    sdram_ref_timer #(
        .REF_PERIOD (REF_PERIOD)
    ) u_ref_timer (
        .clk_i       (sclk),
        .rst_ni      (s_rst_n),
        .init_done_i (init_done),
        .grant_i     (ref_grant),
        .ref_req_o   (ref_req),
        .ref_miss_o  (ref_miss)
    );

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q   <= S_INIT;
            tmo_q     <= '0;
            ref_en_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            arb_err_q <= 1'b0;
            cke_q     <= 1'b1;
        end else begin
            ref_en_q <= 1'b0;
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            cke_q    <= 1'b1;
            // counter is zero on the first cycle of every grant
            tmo_q    <= '0;
            case (state_q)
                S_INIT: begin
                    if (init_done) state_q <= S_ARBIT;
                end
                S_ARBIT: begin
                    if (ref_req) begin
                        state_q  <= S_REF;
                        ref_en_q <= 1'b1;
                    end else if (wr_req) begin
                        state_q <= S_WR;
                        wr_en_q <= 1'b1;
                    end else if (rd_req) begin
                        state_q <= S_RD;
                        rd_en_q <= 1'b1;
                    end
                end
                S_REF, S_WR, S_RD: begin
                    tmo_q <= tmo_q + TMO_W'(1);
                    if ((state_q == S_REF && flag_ref_end) ||
                        (state_q == S_WR  && flag_wr_end)  ||
                        (state_q == S_RD  && flag_rd_end)) begin
                        state_q <= S_ARBIT;
                    end else if (tmo_hit) begin
                        state_q   <= S_ARBIT;
                        arb_err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= init_done ? S_ARBIT : S_INIT;
                end
            endcase
        end
    end

    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = '0;
        sdram_bank = '0;
        case (state_q)
            S_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            S_REF: begin
                sdram_cmd  = ref_cmd;
                sdram_addr = ref_addr;
            end
            S_WR: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
                sdram_bank = wr_bank;
            end
            S_RD: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_bank = rd_bank;
            end
            default: ;
        endcase
    end

    assign ref_en    = ref_en_q;
    assign wr_en     = wr_en_q;
    assign rd_en     = rd_en_q;
    assign arb_err   = arb_err_q;
    assign sdram_cke = cke_q;

endmodule
